// File: rtl/cs_y_collector.sv
`default_nettype none
// ============================================================================
//  Module      : cs_y_collector
//  Description : Discards the first WARMUP enabled Y samples while the
//                upstream CS window fills. Later samples go into a show-ahead
//                FIFO with a sticky overflow flag and running min/max tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module cs_y_collector #(
  parameter int WARMUP = 9,
  parameter int DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] Y,
  input  logic       en,
  output logic [9:0] dout,
  output logic       dout_vld,
  input  logic       dout_rdy,
  output logic [4:0] count,
  output logic       ovf,
  output logic [9:0] y_max,
  output logic [9:0] y_min
);

  localparam int         c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         c_WW    = $clog2(WARMUP + 2);
  localparam logic [c_WW-1:0] c_WARM  = c_WW'(WARMUP);
  localparam logic [4:0] c_FULL  = 5'(DEPTH);

  logic [9:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [4:0]      r_count;
  logic [c_WW-1:0] r_wcnt;
  logic            r_ovf;
  logic [9:0]      r_ymax;
  logic [9:0]      r_ymin;

  logic w_cap;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  // Capture, pop, write and drop qualifiers for this cycle
  always_comb begin
    w_cap  = en && (r_wcnt == c_WARM);
    w_full = (r_count == c_FULL);
    w_pop  = (r_count != 5'd0) && dout_rdy;
    w_wr   = w_cap && (!w_full || w_pop);
    w_drop = w_cap && w_full && !w_pop;
  end

  // Warm-up counter: counts enabled samples up to WARMUP and then holds
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt <= '0;
    end else if (en && (r_wcnt != c_WARM)) begin
      r_wcnt <= r_wcnt + c_WW'(1);
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (!reset && w_wr) begin
      r_mem[r_wptr] <= Y;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 5'd1;
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - 5'd1;
      end
    end
  end

  // Sticky overflow flag, set when a captured sample finds no room
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  // Running unsigned extremes over samples actually written
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ymax <= 10'h000;
      r_ymin <= 10'h3FF;
    end else if (w_wr) begin
      if (Y > r_ymax) begin
        r_ymax <= Y;
      end
      if (Y < r_ymin) begin
        r_ymin <= Y;
      end
    end
  end

  // Show-ahead outputs straight from the registered state
  always_comb begin
    dout     = r_mem[r_rptr];
    dout_vld = (r_count != 5'd0);
    count    = r_count;
    ovf      = r_ovf;
    y_max    = r_ymax;
    y_min    = r_ymin;
  end

endmodule
`default_nettype wire

// File: tb/tb_cs_y_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cs_y_collector
//  Description : Self-checking bench for cs_y_collector. A queue-based
//                reference model predicts every sample that should come out;
//                a monitor pops and compares whenever the DUT hands one over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cs_y_collector;

  localparam int WARMUP = 9;
  localparam int DEPTH  = 16;

  logic       clk;
  logic       reset;
  logic [9:0] Y;
  logic       en;
  logic [9:0] dout;
  logic       dout_vld;
  logic       dout_rdy;
  logic [4:0] count;
  logic       ovf;
  logic [9:0] y_max;
  logic [9:0] y_min;

  int n_checks = 0;
  int n_errors = 0;

  cs_y_collector #(.WARMUP(WARMUP), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .Y        (Y),
    .en       (en),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .count    (count),
    .ovf      (ovf),
    .y_max    (y_max),
    .y_min    (y_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the collector should look like after each edge
  int         m_wcnt;
  int         m_count;
  bit         m_ovf;
  int         m_ymax;
  int         m_ymin;
  bit         m_valid = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compare present state, then advance on the inputs for the next edge
  always @(negedge clk) begin
    int cap;
    int pop;
    int wr;
    if (m_valid) begin
      chk("count",    int'(count),    m_count);
      chk("dout_vld", int'(dout_vld), int'(m_count != 0));
      chk("ovf",      int'(ovf),      int'(m_ovf));
      chk("y_max",    int'(y_max),    m_ymax);
      chk("y_min",    int'(y_min),    m_ymin);
    end
    if (reset) begin
      m_wcnt  = 0;
      m_count = 0;
      m_ovf   = 0;
      m_ymax  = 0;
      m_ymin  = 1023;
      exp_q.delete();
      m_valid = 1;
    end else if (m_valid) begin
      cap = int'(en && (m_wcnt == WARMUP));
      if (en && m_wcnt < WARMUP) m_wcnt++;
      pop = int'((m_count != 0) && dout_rdy);
      wr  = int'((cap != 0) && (m_count < DEPTH || pop != 0));
      if (cap != 0 && wr == 0) m_ovf = 1;
      if (wr != 0) begin
        exp_q.push_back(Y);
        if (int'(Y) > m_ymax) m_ymax = int'(Y);
        if (int'(Y) < m_ymin) m_ymin = int'(Y);
      end
      m_count = m_count + wr - pop;
    end
  end

  // Monitor: every accepted output must be the oldest predicted sample
  always @(negedge clk) begin
    logic [9:0] e;
    if (m_valid && !reset && dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dout: got %0d with nothing expected at %0t", dout, $time);
      end else begin
        e = exp_q.pop_front();
        chk("dout", int'(dout), int'(e));
      end
    end
  end

  task automatic drive(input bit r, input bit e, input int y, input bit rdy);
    @(posedge clk);
    #2;
    reset    = r;
    en       = e;
    Y        = 10'(y);
    dout_rdy = rdy;
  endtask

  task automatic sample_point();
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
  endtask

  task automatic warmup_fill(input bit rdy);
    for (int i = 0; i < WARMUP; i++) drive(0, 1, 900 + i, rdy);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; Y = '0; dout_rdy = 1'b0;

    // Warm-up: Y=k on the k-th enabled edge, consumer always ready
    do_reset();
    for (int k = 1; k <= 20; k++) drive(0, 1, k, 1);
    sample_point();

    // Fill and overflow, then drain in order
    do_reset();
    warmup_fill(0);
    sample_point();
    chk("pre_cap_y_max", int'(y_max), 0);
    chk("pre_cap_y_min", int'(y_min), 1023);
    for (int n = 0; n < 20; n++) drive(0, 1, 10 + n, 0);
    sample_point();
    chk("fill_count", int'(count), 16);
    chk("fill_ovf",   int'(ovf),   1);
    chk("fill_head",  int'(dout),  10);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1);
    sample_point();
    chk("drain_count", int'(count), 0);

    // Full FIFO with a capture and a pop on the same edge
    do_reset();
    warmup_fill(0);
    for (int n = 0; n < 16; n++) drive(0, 1, 10 + n, 0);
    drive(0, 1, 500, 1);
    sample_point();
    chk("fullpop_count", int'(count), 16);
    chk("fullpop_ovf",   int'(ovf),   0);
    chk("fullpop_head",  int'(dout),  11);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1);
    sample_point();

    // Min/max tracking over extreme values
    do_reset();
    warmup_fill(1);
    drive(0, 1, 300, 1);
    drive(0, 1, 5, 1);
    drive(0, 1, 1023, 1);
    drive(0, 1, 0, 1);
    sample_point();
    chk("mm_y_max", int'(y_max), 1023);
    chk("mm_y_min", int'(y_min), 0);

    // Gaps in en during warm-up: only enabled edges count
    do_reset();
    for (int i = 0; i < 18; i++) drive(0, (i % 2) == 0, 100 + i, 0);
    sample_point();
    chk("gap_count_9en", int'(count), 0);
    drive(0, 1, 77, 0);
    sample_point();
    chk("gap_count_10en", int'(count), 1);

    // Mid-stream reset with data present and overflow set
    do_reset();
    warmup_fill(0);
    for (int n = 0; n < 17; n++) drive(0, 1, 40 + n, 0);
    for (int i = 0; i < 11; i++) drive(0, 0, 0, 1);
    sample_point();
    chk("mid_pre_count", int'(count), 5);
    chk("mid_pre_ovf",   int'(ovf),   1);
    drive(1, 1, 3, 1);
    sample_point();
    chk("mid_count", int'(count),    0);
    chk("mid_vld",   int'(dout_vld), 0);
    chk("mid_ovf",   int'(ovf),      0);
    warmup_fill(0);
    sample_point();
    chk("mid_warm_count", int'(count), 0);

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 1023)),
            $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 8));
    end

    // Drain whatever is left, bounded by a cycle budget
    for (int i = 0; i < 4 * DEPTH && count != 0; i++) drive(0, 0, 0, 1);
    sample_point();
    chk("final_empty", int'(count), 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cs_y_collector.md
CS_Y_COLLECTOR -- requirements
Module: cs_y_collector

Interface
Parameters:
REQ-001 SHALL have parameter WARMUP, default 9: number of enabled cycles after reset whose Y is discarded (the CS window fill).
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries, a power of two.
Ports:
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port Y  input  10: result sample from the upstream CS stage.
REQ-006 SHALL have port en  input  1: a new Y is present this cycle.
REQ-007 SHALL have port dout  output  10: FIFO head data.
REQ-008 SHALL have port dout_vld  output  1: dout holds valid data.
REQ-009 SHALL have port dout_rdy  input  1: consumer accepts dout this cycle.
REQ-010 SHALL have port count  output  5: current FIFO occupancy, 0..DEPTH.
REQ-011 SHALL have port ovf  output  1: sticky flag, a captured sample was dropped.
REQ-012 SHALL have port y_max  output  10: largest Y written since reset.
REQ-013 SHALL have port y_min  output  10: smallest Y written since reset.

Function
REQ-014 SHALL keep warm-up counter wcnt: reset 0; +1 on each en=1 edge while wcnt<WARMUP; saturates at WARMUP.
REQ-015 SHALL define cap = en & (wcnt==WARMUP); the first WARMUP enabled Y values are discarded, and the (WARMUP+1)th and all later ones are captured.
REQ-016 SHALL hold wcnt and take no action on en=0 cycles.
REQ-017 SHALL define pop = dout_vld & dout_rdy; each pop advances the read pointer by one entry.
REQ-018 SHALL write Y at the write pointer on cap when count<DEPTH, or when count==DEPTH and pop is also asserted.
REQ-019 SHALL, on cap with count==DEPTH and no pop, drop Y, leave the FIFO unchanged, and set ovf to 1 from the next cycle.
REQ-020 SHALL clear ovf only on reset.
REQ-021 SHALL update count as +1 for a write only, -1 for a pop only, and unchanged for a write plus a pop or for neither.
REQ-022 SHALL drive dout = mem[rptr] combinationally (show-ahead) and dout_vld = (count!=0).
REQ-023 SHALL provide no bypass: a write into an empty FIFO makes dout_vld high on the next cycle.
REQ-024 SHALL drive dout as don't-care when dout_vld=0, and SHALL ignore dout_rdy while dout_vld=0.
REQ-025 SHALL wrap the pointers modulo DEPTH.
REQ-026 SHALL, on each write only, set y_max to max(y_max, Y) and y_min to min(y_min, Y); dropped samples do not update them.
REQ-027 SHALL compare Y values as unsigned 10-bit quantities.

Reset
REQ-028 SHALL, on an edge with reset=1 regardless of en or dout_rdy, set wcnt=0, pointers=0, count=0, dout_vld=0, ovf=0, y_max=10'h000 and y_min=10'h3FF.
REQ-029 SHALL apply reset mid-stream: FIFO contents are abandoned and warm-up restarts, with cap first asserting at the (WARMUP+1)th en after reset falls.
REQ-030 SHALL give reset priority over cap and pop in the same cycle.

Verification
REQ-031 SHALL verify warm-up: reset 2 cycles, en=1, Y=k on the k-th edge, dout_rdy=1 -> first dout=10'h00A, dout_vld rises one cycle after edge 10, then 11, 12, ... with count staying at 1.
REQ-032 SHALL verify fill/overflow: dout_rdy=0, 9+20 enabled edges with Y=10+n (n=0..19) -> count=16, ovf=1 after the 17th capture, FIFO holds 10..25, and draining yields exactly 10..25 in order.
REQ-033 SHALL verify simultaneous full write and pop: count=16, cap and pop in the same cycle -> count stays 16, ovf stays 0, head advances, and the new Y becomes the tail entry.
REQ-034 SHALL verify min/max: captured Y sequence 300, 5, 1023, 0 -> y_max=1023, y_min=0; before any capture y_max=0 and y_min=1023.
REQ-035 SHALL verify gaps: en toggling 1,0,1,0 during warm-up -> wcnt advances only on en=1 edges, and cap first asserts on the 10th en=1 edge.
REQ-036 SHALL verify mid-stream reset: reset=1 with count=5, ovf=1 -> the next cycle shows count=0, dout_vld=0, ovf=0, and 9 further enabled edges produce no capture.
